// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: MemOP codes and FSM state values.
package lsu_pkg;

  localparam logic [2:0] MEMOP_B  = 3'b000;
  localparam logic [2:0] MEMOP_H  = 3'b001;
  localparam logic [2:0] MEMOP_W  = 3'b010;
  localparam logic [2:0] MEMOP_BU = 3'b100;
  localparam logic [2:0] MEMOP_HU = 3'b101;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_REQ  = 2'd1,
    LSU_WAIT = 2'd2,
    LSU_DONE = 2'd3
  } lsu_state_e;

endpackage

// File: rtl/lsu_lane.sv
// Combinational byte-lane logic: access legality, store replication/masking,
// and load shift with sign/zero extension.
module lsu_lane
  import lsu_pkg::*;
(
  input  logic        chk_ren_i,
  input  logic        chk_wen_i,
  input  logic [2:0]  chk_op_i,
  input  logic [1:0]  chk_off_i,
  output logic        op_err_o,
  input  logic [2:0]  op_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] resp_i,
  output logic [31:0] lane_wdata_o,
  output logic [3:0]  lane_wmask_o,
  output logic [31:0] load_o
);

  logic [31:0] shifted;

  // Reserved encodings are x11 and 110; unsigned variants exist for loads only.
  always_comb begin
    op_err_o = 1'b0;
    if (chk_ren_i && chk_wen_i) op_err_o = 1'b1;
    if (chk_op_i[1:0] == 2'b11 || chk_op_i == 3'b110) op_err_o = 1'b1;
    if (chk_wen_i && chk_op_i[2]) op_err_o = 1'b1;
    if (chk_op_i[1:0] == 2'b01 && chk_off_i[0]) op_err_o = 1'b1;
    if (chk_op_i[1:0] == 2'b10 && chk_off_i != 2'b00) op_err_o = 1'b1;
  end

  always_comb begin
    lane_wdata_o = wdata_i;
    lane_wmask_o = 4'b1111;
    case (op_i[1:0])
      2'b00: begin
        lane_wdata_o = {4{wdata_i[7:0]}};
        lane_wmask_o = 4'b0001 << off_i;
      end
      2'b01: begin
        lane_wdata_o = {2{wdata_i[15:0]}};
        lane_wmask_o = 4'b0011 << off_i;
      end
      default: ;
    endcase
  end

  assign shifted = resp_i >> {off_i, 3'b000};

  always_comb begin
    load_o = resp_i;
    case (op_i)
      MEMOP_B:  load_o = {{24{shifted[7]}}, shifted[7:0]};
      MEMOP_BU: load_o = {24'b0, shifted[7:0]};
      MEMOP_H:  load_o = {{16{shifted[15]}}, shifted[15:0]};
      MEMOP_HU: load_o = {16'b0, shifted[15:0]};
      default:  load_o = resp_i;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: accepts one memory op at a time, runs a single valid/ready
// bus transaction for it and returns extended load data with a one-cycle pulse.
module lsu
  import lsu_pkg::*;
#(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        mem_ren,
  input  logic        mem_wen,
  input  logic [2:0]  mem_op,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        out_valid,
  output logic [31:0] rdata,
  output logic        err,
  output logic        bus_req_valid,
  input  logic        bus_req_ready,
  output logic [31:0] bus_req_addr,
  output logic        bus_req_wen,
  output logic [31:0] bus_req_wdata,
  output logic [3:0]  bus_req_wmask,
  input  logic        bus_resp_valid,
  input  logic [31:0] bus_resp_data
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  lsu_state_e  state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [2:0]  op_q, op_d;
  logic        wen_q, wen_d;
  logic        err_q, err_d;
  logic [31:0] rdata_q, rdata_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic        accept;
  logic        opErr;
  logic        timeUp;
  logic [31:0] laneWdata;
  logic [3:0]  laneWmask;
  logic [31:0] loadData;
  logic [31:0] loadResult;

  lsu_lane u_lane (
    .chk_ren_i    (mem_ren),
    .chk_wen_i    (mem_wen),
    .chk_op_i     (mem_op),
    .chk_off_i    (addr[1:0]),
    .op_err_o     (opErr),
    .op_i         (op_q),
    .off_i        (addr_q[1:0]),
    .wdata_i      (wdata_q),
    .resp_i       (bus_resp_data),
    .lane_wdata_o (laneWdata),
    .lane_wmask_o (laneWmask),
    .load_o       (loadData)
  );

  assign accept     = (state_q == LSU_IDLE) && in_valid && (mem_ren || mem_wen);
  assign timeUp     = (cnt_q == CW'(TIMEOUT_CYC - 1));
  assign loadResult = wen_q ? 32'h0 : loadData;

  // A response captured in the same cycle the bus accepts the request skips WAIT;
  // completion always wins over a timeout that lands in the same cycle.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    op_d    = op_q;
    wen_d   = wen_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    cnt_d   = cnt_q;
    case (state_q)
      LSU_IDLE: begin
        if (accept) begin
          addr_d  = addr;
          wdata_d = wdata;
          op_d    = mem_op;
          wen_d   = mem_wen;
          err_d   = opErr;
          rdata_d = 32'h0;
          cnt_d   = '0;
          state_d = opErr ? LSU_DONE : LSU_REQ;
        end
      end
      LSU_REQ: begin
        cnt_d = cnt_q + CW'(1);
        if (bus_req_ready && bus_resp_valid) begin
          rdata_d = loadResult;
          state_d = LSU_DONE;
        end else if (timeUp) begin
          err_d   = 1'b1;
          state_d = LSU_DONE;
        end else if (bus_req_ready) begin
          state_d = LSU_WAIT;
        end
      end
      LSU_WAIT: begin
        cnt_d = cnt_q + CW'(1);
        if (bus_resp_valid) begin
          rdata_d = loadResult;
          state_d = LSU_DONE;
        end else if (timeUp) begin
          err_d   = 1'b1;
          state_d = LSU_DONE;
        end
      end
      LSU_DONE: state_d = LSU_IDLE;
      default:  state_d = LSU_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= LSU_IDLE;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      op_q    <= 3'b000;
      wen_q   <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= 32'h0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      op_q    <= op_d;
      wen_q   <= wen_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
    end
  end

  // Bus fields are forced to zero outside REQ so idle and reset outputs stay quiet.
  assign in_ready      = (state_q == LSU_IDLE);
  assign out_valid     = (state_q == LSU_DONE);
  assign err           = out_valid && err_q;
  assign rdata         = rdata_q;
  assign bus_req_valid = (state_q == LSU_REQ);
  assign bus_req_addr  = bus_req_valid ? {addr_q[31:2], 2'b00} : 32'h0;
  assign bus_req_wen   = bus_req_valid && wen_q;
  assign bus_req_wdata = bus_req_valid ? laneWdata : 32'h0;
  assign bus_req_wmask = bus_req_wen ? laneWmask : 4'b0000;

endmodule
